// File: rtl/mac_pkg.sv
// Shared state type, default widths and index helper for the mac scheduler.
// Latency: none; declarations only.
// Backpressure: not applicable.
package mac_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_LINES = 5;
  localparam int unsigned MAX_REQ        = 8;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    WAIT_BUSY,
    WAIT_IDLE,
    RESP
  } sched_state_e;

  // Index of the set bit of a one-hot vector (zero when no bit is set).
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mac_rr_scheduler_rr_arbiter.sv
// Stateless round-robin pick: first request at or after ptr_i, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is taken.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic [N-1:0] req_rot;
  logic [N-1:0] gnt_rot;

  // Position i of the rotated view corresponds to requester (i + ptr) mod N.
  function automatic logic [PW-1:0] wrap(input int i, input logic [PW-1:0] p);
    return PW'((i + int'(p)) % int'(N));
  endfunction

  // Rotate so the pointer sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    req_rot = '0;
    gnt_o   = '0;
    for (int i = 0; i < N; i++) begin
      req_rot[i] = req_i[wrap(i, ptr_i)];
    end
    gnt_rot = req_rot & (-req_rot);
    for (int i = 0; i < N; i++) begin
      gnt_o[wrap(i, ptr_i)] = gnt_rot[i];
    end
  end

endmodule

// File: rtl/mac_rr_scheduler.sv
// Round-robin front end sharing one mac engine between NUM_REQ requesters.
// Latency: grant 1 cycle after request; samples pass through combinationally; response 1 cycle after engine idle.
// Backpressure: owner ready follows !mac_full_i; response held until the owner's res_ready_i.
module mac_rr_scheduler
  import mac_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_LINES     = DEF_ADDR_LINES,
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*ADDR_LINES-1:0] terms_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
  input  logic [NUM_REQ-1:0]            valid_i,
  input  logic [NUM_REQ-1:0]            last_i,
  output logic [NUM_REQ-1:0]            ready_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic [NUM_REQ-1:0]            res_valid_o,
  input  logic [NUM_REQ-1:0]            res_ready_i,
  output logic [DATA_WIDTH-1:0]         result_o,
  output logic                          err_o,
  output logic [DATA_WIDTH-1:0]         mac_signal_o,
  output logic                          mac_wr_en_o,
  output logic                          mac_last_o,
  output logic [ADDR_LINES-1:0]         mac_terms_o,
  input  logic                          mac_full_i,
  input  logic                          mac_idle_i,
  input  logic [DATA_WIDTH-1:0]         mac_result_i
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  sched_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [ADDR_LINES-1:0] terms_q, terms_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [NUM_REQ-1:0]    res_vld_q, res_vld_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  err_q, err_d;

  logic [NUM_REQ-1:0]    arb_gnt;
  logic [IW-1:0]         arb_idx;
  logic [IW-1:0]         own_idx;

  logic [DATA_WIDTH-1:0] data_arr  [NUM_REQ];
  logic [ADDR_LINES-1:0] terms_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign data_arr[k]  = data_i[k*DATA_WIDTH +: DATA_WIDTH];
    assign terms_arr[k] = terms_i[k*ADDR_LINES +: ADDR_LINES];
  end

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (IW)
  ) u_arb (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt)
  );

  assign arb_idx = IW'(onehot_to_idx(MAX_REQ'(arb_gnt)));
  assign own_idx = IW'(onehot_to_idx(MAX_REQ'(grant_q)));

  assign grant_o     = grant_q;
  assign res_valid_o = res_vld_q;
  assign result_o    = result_q;
  assign err_o       = err_q;
  assign mac_terms_o = terms_q;

  // Sample path: only the owner is connected to the engine, and only while streaming.
  always_comb begin
    ready_o      = '0;
    mac_wr_en_o  = 1'b0;
    mac_signal_o = '0;
    mac_last_o   = 1'b0;
    if (state_q == STREAM) begin
      ready_o      = grant_q & {NUM_REQ{!mac_full_i}};
      mac_wr_en_o  = valid_i[own_idx] & !mac_full_i;
      mac_signal_o = data_arr[own_idx];
      mac_last_o   = last_i[own_idx] & mac_wr_en_o;
    end
  end

  // Job sequencing: arbitrate, stream, wait for the engine to run, return the result.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    terms_d   = terms_q;
    timer_d   = timer_q;
    res_vld_d = res_vld_q;
    result_d  = result_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          grant_d = arb_gnt;
          terms_d = terms_arr[arb_idx];
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (mac_last_o) begin
          timer_d = '0;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!mac_idle_i) begin
          timer_d = '0;
          state_d = WAIT_IDLE;
        end else if (timer_q == TMAX) begin
          result_d  = '0;
          err_d     = 1'b1;
          res_vld_d = grant_q;
          state_d   = RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_IDLE: begin
        if (mac_idle_i) begin
          result_d  = mac_result_i;
          err_d     = 1'b0;
          res_vld_d = grant_q;
          state_d   = RESP;
        end else if (timer_q == TMAX) begin
          result_d  = '0;
          err_d     = 1'b1;
          res_vld_d = grant_q;
          state_d   = RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RESP: begin
        // Re-arbitration happens in IDLE, so the next grant lands one cycle later.
        if (|(res_vld_q & res_ready_i)) begin
          res_vld_d = '0;
          grant_d   = '0;
          err_d     = 1'b0;
          ptr_d     = (own_idx == IW'(NUM_REQ - 1)) ? '0 : own_idx + IW'(1);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any job in flight without a response.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      terms_q   <= '0;
      timer_q   <= '0;
      res_vld_q <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      terms_q   <= terms_d;
      timer_q   <= timer_d;
      res_vld_q <= res_vld_d;
      result_q  <= result_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_mac_rr_scheduler.sv
// Randomized scoreboard bench for mac_rr_scheduler; the bench also plays the mac engine.
// Latency: expectations are queued at stimulus time and popped by the negedge monitor.
// Backpressure: mac_full_i and res_ready_i are driven randomly and in directed bursts.
module tb_mac_rr_scheduler;

  localparam int DW = 32;
  localparam int AL = 5;
  localparam int NR = 4;
  localparam int TO = 16;

  logic             clk_i = 1'b0;
  logic             rstn_i;
  logic [NR-1:0]    req_i;
  logic [NR*AL-1:0] terms_i;
  logic [NR*DW-1:0] data_i;
  logic [NR-1:0]    valid_i;
  logic [NR-1:0]    last_i;
  logic [NR-1:0]    ready_o;
  logic [NR-1:0]    grant_o;
  logic [NR-1:0]    res_valid_o;
  logic [NR-1:0]    res_ready_i;
  logic [DW-1:0]    result_o;
  logic             err_o;
  logic [DW-1:0]    mac_signal_o;
  logic             mac_wr_en_o;
  logic             mac_last_o;
  logic [AL-1:0]    mac_terms_o;
  logic             mac_full_i;
  logic             mac_idle_i;
  logic [DW-1:0]    mac_result_i;

  always #5 clk_i = ~clk_i;

  mac_rr_scheduler #(
    .DATA_WIDTH     (DW),
    .ADDR_LINES     (AL),
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .req_i        (req_i),
    .terms_i      (terms_i),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .last_i       (last_i),
    .ready_o      (ready_o),
    .grant_o      (grant_o),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .result_o     (result_o),
    .err_o        (err_o),
    .mac_signal_o (mac_signal_o),
    .mac_wr_en_o  (mac_wr_en_o),
    .mac_last_o   (mac_last_o),
    .mac_terms_o  (mac_terms_o),
    .mac_full_i   (mac_full_i),
    .mac_idle_i   (mac_idle_i),
    .mac_result_i (mac_result_i)
  );

  typedef struct { int owner; logic [AL-1:0] terms; } gnt_item_t;
  typedef struct { logic [DW-1:0] dat; logic last; } wr_item_t;
  typedef struct { int owner; logic [DW-1:0] result; logic err; } rsp_item_t;

  gnt_item_t gnt_q[$];
  wr_item_t  wr_q[$];
  rsp_item_t rsp_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int model_ptr   = 0;

  gnt_item_t     mon_g;
  wr_item_t      mon_w;
  rsp_item_t     mon_r;
  logic [AL-1:0] cur_terms = '0;
  logic [NR-1:0] prev_grant = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant, write or response.
  always @(negedge clk_i) begin
    if (!rstn_i) begin
      prev_grant = '0;
    end else begin
      if (grant_o != '0 && prev_grant == '0) begin
        if (gnt_q.size() == 0) begin
          chk("grant_unexpected", 64'(grant_o), 64'd0);
        end else begin
          mon_g = gnt_q.pop_front();
          chk("grant", 64'(grant_o), 64'(1 << mon_g.owner));
          chk("terms_latch", 64'(mac_terms_o), 64'(mon_g.terms));
          cur_terms = mon_g.terms;
        end
      end
      prev_grant = grant_o;
      chk("ready_owner_only", 64'(ready_o & ~grant_o), 64'd0);
      if (mac_full_i) chk("ready_when_full", 64'(ready_o), 64'd0);
      if (mac_wr_en_o) begin
        if (wr_q.size() == 0) begin
          chk("wr_unexpected", 64'(mac_wr_en_o), 64'd0);
        end else begin
          mon_w = wr_q.pop_front();
          chk("wr_data", 64'(mac_signal_o), 64'(mon_w.dat));
          chk("wr_last", 64'(mac_last_o), 64'(mon_w.last));
          chk("terms_hold", 64'(mac_terms_o), 64'(cur_terms));
        end
      end else begin
        chk("last_without_wr", 64'(mac_last_o), 64'd0);
      end
      if (res_valid_o != '0) begin
        if (rsp_q.size() == 0) begin
          chk("resp_unexpected", 64'(res_valid_o), 64'd0);
        end else begin
          mon_r = rsp_q[0];
          chk("res_valid", 64'(res_valid_o), 64'(1 << mon_r.owner));
          chk("result", 64'(result_o), 64'(mon_r.result));
          chk("err", 64'(err_o), 64'(mon_r.err));
          if (|(res_valid_o & res_ready_i)) void'(rsp_q.pop_front());
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"},     64'(grant_o), 64'd0);
    chk({tag, "_ready"},     64'(ready_o), 64'd0);
    chk({tag, "_res_valid"}, 64'(res_valid_o), 64'd0);
    chk({tag, "_result"},    64'(result_o), 64'd0);
    chk({tag, "_err"},       64'(err_o), 64'd0);
    chk({tag, "_wr_en"},     64'(mac_wr_en_o), 64'd0);
    chk({tag, "_signal"},    64'(mac_signal_o), 64'd0);
    chk({tag, "_last"},      64'(mac_last_o), 64'd0);
    chk({tag, "_terms"},     64'(mac_terms_o), 64'd0);
  endtask

  // One job: endm 0 = normal engine run, 1 = engine never leaves idle, 2 = engine never finishes.
  task automatic run_job(input logic [NR-1:0] reqs, input int endm, input bit bp5,
                         input bit rst_mid, input bit directed, input int stall);
    int            owner;
    int            ix;
    int            nsamp;
    int            cyc;
    int            w;
    int            st;
    bit            acc;
    logic [AL-1:0] tsel;
    logic [DW-1:0] d;
    logic [DW-1:0] r;
    gnt_item_t     gi;
    wr_item_t      wi;
    rsp_item_t     ri;

    owner = -1;
    for (int k = 0; k < NR; k++) begin
      ix = (model_ptr + k) % NR;
      if (owner < 0 && reqs[ix]) owner = ix;
    end
    for (int k = 0; k < NR; k++) terms_i[k*AL +: AL] = AL'($urandom_range(0, 31));
    if (directed) terms_i[owner*AL +: AL] = AL'(3);
    tsel = terms_i[owner*AL +: AL];
    gi.owner = owner;
    gi.terms = tsel;
    gnt_q.push_back(gi);
    req_i = reqs;

    cyc = 0;
    do begin
      @(posedge clk_i); #1;
      cyc++;
    end while (grant_o == '0 && cyc < 8);
    chk("grant_latency", 64'(cyc), 64'd1);
    // Terms must stay latched even though the inputs move after the grant.
    terms_i = {$urandom, $urandom} ^ NR*AL'(0);

    nsamp = directed ? 4 : (rst_mid ? 3 : int'($urandom_range(1, 4)));
    for (int s = 0; s < nsamp; s++) begin
      d = directed ? DW'(s + 1) : DW'($urandom);
      data_i = {$urandom, $urandom, $urandom, $urandom};
      data_i[owner*DW +: DW] = d;
      valid_i = NR'($urandom);
      valid_i[owner] = 1'b1;
      last_i = NR'($urandom);
      last_i[owner] = (s == nsamp - 1);
      wi.dat  = d;
      wi.last = (s == nsamp - 1);
      wr_q.push_back(wi);
      acc = 1'b0;
      w = 0;
      while (!acc && w < 40) begin
        if (bp5 && s == 1 && w < 5) mac_full_i = 1'b1;
        else if (directed)          mac_full_i = 1'b0;
        else                        mac_full_i = ($urandom_range(0, 3) == 0);
        @(posedge clk_i);
        acc = !mac_full_i;
        #1;
        w++;
      end
      chk("sample_accepted", 64'(acc), 64'd1);
      mac_full_i = 1'b0;
      valid_i = NR'($urandom);
      valid_i[owner] = 1'b0;
      if (rst_mid && s == 0) begin
        // Owner presents another sample so a missed reset would show up as a write.
        valid_i[owner] = 1'b1;
        #1 rstn_i = 1'b0;
        #1 chk_all_zero("rst_mid");
        req_i = '0;
        valid_i = '0;
        last_i = '0;
        mac_idle_i = 1'b1;
        gnt_q.delete();
        wr_q.delete();
        rsp_q.delete();
        model_ptr = 0;
        repeat (2) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        return;
      end
      if (!directed && s < nsamp - 1) begin
        repeat ($urandom_range(0, 1)) begin
          @(posedge clk_i); #1;
        end
      end
    end
    valid_i = '0;
    last_i = '0;

    if (endm == 0) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk_i); #1;
      end
      mac_idle_i = 1'b0;
      repeat ($urandom_range(1, 6)) begin
        @(posedge clk_i); #1;
      end
      r = DW'($urandom);
      mac_result_i = r;
      ri.owner = owner; ri.result = r; ri.err = 1'b0;
      rsp_q.push_back(ri);
      mac_idle_i = 1'b1;
    end else begin
      mac_result_i = DW'($urandom) | DW'(1);
      if (endm == 2) mac_idle_i = 1'b0;
      ri.owner = owner; ri.result = '0; ri.err = 1'b1;
      rsp_q.push_back(ri);
    end

    cyc = 0;
    while (res_valid_o == '0 && cyc < 60) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    chk("resp_arrived", 64'(res_valid_o), 64'(1 << owner));
    if (endm == 1) chk("timeout_wait_busy_cycles", 64'(cyc), 64'd16);
    if (endm == 2) chk("timeout_wait_idle_cycles", 64'(cyc), 64'd17);

    st = (stall >= 0) ? stall : int'($urandom_range(0, 10));
    for (int i = 0; i < st; i++) begin
      res_ready_i = NR'($urandom) & ~(NR'(1) << owner);
      if (i == 2) req_i[2] = 1'b1;
      @(posedge clk_i); #1;
      chk("grant_held_in_resp", 64'(grant_o), 64'(1 << owner));
      chk("res_valid_held", 64'(res_valid_o), 64'(1 << owner));
    end
    res_ready_i = NR'($urandom) | (NR'(1) << owner);
    @(posedge clk_i); #1;
    res_ready_i = '0;
    mac_idle_i = 1'b1;
    chk("idle_grant_cleared", 64'(grant_o), 64'd0);
    chk("idle_res_valid_cleared", 64'(res_valid_o), 64'd0);
    chk("idle_err_cleared", 64'(err_o), 64'd0);
    model_ptr = (owner + 1) % NR;
  endtask

  initial begin
    rstn_i = 1'b0;
    req_i = '0;
    terms_i = '0;
    data_i = '0;
    valid_i = '0;
    last_i = '0;
    res_ready_i = '0;
    mac_full_i = 1'b0;
    mac_idle_i = 1'b1;
    mac_result_i = '0;
    repeat (3) @(posedge clk_i);
    #1 chk_all_zero("reset");
    rstn_i = 1'b1;

    run_job(4'b0001, 0, 1'b0, 1'b0, 1'b1, 0);
    run_job(4'b0110, 0, 1'b0, 1'b1, 1'b0, -1);
    for (int i = 0; i < 5; i++) run_job(4'b1111, 0, 1'b0, 1'b0, 1'b0, 0);
    run_job(4'b0010, 0, 1'b1, 1'b0, 1'b0, -1);
    run_job(4'b1000, 1, 1'b0, 1'b0, 1'b0, -1);
    run_job(4'b0001, 0, 1'b0, 1'b0, 1'b0, 10);
    run_job(4'b0100, 2, 1'b0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 40; i++) begin
      int e;
      e = int'($urandom_range(0, 5));
      run_job(NR'($urandom_range(1, 15)), (e < 4) ? 0 : e - 3, 1'b0, 1'b0, 1'b0, -1);
    end
    run_job(4'b1111, 0, 1'b0, 1'b1, 1'b0, -1);
    run_job(4'b0100, 0, 1'b0, 1'b0, 1'b0, -1);
    run_job(4'b1111, 0, 1'b0, 1'b0, 1'b0, -1);
    req_i = '0;
    repeat (5) @(posedge clk_i);
    #1 chk("queues_drained", 64'(gnt_q.size() + wr_q.size() + rsp_q.size()), 64'd0);
    chk("final_grant", 64'(grant_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mac_rr_scheduler.md
Name: mac_rr_scheduler

Overview:
- Shares one mac engine (signal FIFO + coefficient ROM + datapath + controller) between NUM_REQ requesters using round-robin arbitration.
- The granted requester streams samples with valid/ready. Its terms value is held on the engine for the whole job.
- The scheduler detects job completion from the engine's idle_o, captures result_o and returns it to the owner with a valid/ready response.
- Sits between the requester clients and the mac instance in the top level.

Parameters:
DATA_WIDTH, 32, sample/result width; must match the mac instance
ADDR_LINES, 5, width of terms field; must match the mac instance
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 1024, max cycles in each wait state before abort with error

Ports:
clk_i  in  1  system clock
rstn_i  in  1  asynchronous active-low reset
req_i  in  NUM_REQ  per-requester job request; held until response accepted
terms_i  in  NUM_REQ*ADDR_LINES  per-requester term count, packed, requester k at [k*ADDR_LINES +: ADDR_LINES]
data_i  in  NUM_REQ*DATA_WIDTH  per-requester sample, packed likewise
valid_i  in  NUM_REQ  sample valid
last_i  in  NUM_REQ  marks final sample of job, qualified by valid_i
ready_o  out  NUM_REQ  sample accepted when valid_i & ready_o
grant_o  out  NUM_REQ  one-hot current owner, registered
res_valid_o  out  NUM_REQ  one-hot response valid
res_ready_i  in  NUM_REQ  response accept
result_o  out  DATA_WIDTH  captured result, stable while res_valid_o != 0
err_o  out  1  response flags a timeout, valid with res_valid_o
mac_signal_o  out  DATA_WIDTH  to mac signal_i
mac_wr_en_o  out  1  to mac wr_en_i
mac_last_o  out  1  to mac last_i
mac_terms_o  out  ADDR_LINES  to mac terms_i, registered
mac_full_i  in  1  from mac full_o
mac_idle_i  in  1  from mac idle_o
mac_result_i  in  DATA_WIDTH  from mac result_o

Behaviour:
- Reset (async, rstn_i low): state IDLE. All outputs 0 (grant_o, ready_o, res_valid_o, result_o, err_o, mac_*_o). Round-robin pointer = 0. Timeout counter = 0. Reset mid-job drops the job with no response; the mac is reset by the same rstn_i.
- State IDLE:
  - If req_i != 0, pick the first set bit at or after the pointer, wrapping around.
  - On the next edge: register grant_o one-hot, latch mac_terms_o = that requester's terms_i, go to STREAM.
  - Grant latency is one cycle from req_i observed.
- State STREAM:
  - ready_o[g] = !mac_full_i, combinational. Only the owner's bit is ever set.
  - mac_wr_en_o = valid_i[g] & ready_o[g]. mac_signal_o = data_i[g]. mac_last_o = last_i[g] & mac_wr_en_o. All are combinational pass-through.
  - A write with last goes to WAIT_BUSY and clears the timer. STREAM itself has no timeout.
  - Non-owner valid_i is ignored.
- State WAIT_BUSY: wait for mac_idle_i = 0, then go to WAIT_IDLE and clear the timer.
- State WAIT_IDLE: when mac_idle_i = 1, register result_o = mac_result_i, err_o = 0, set res_valid_o[g], go to RESP.
- Timeout: in either wait state, when the timer reaches TIMEOUT_CYCLES-1, go to RESP with err_o = 1 and result_o = 0.
- State RESP:
  - res_valid_o[g] holds until res_ready_i[g].
  - On handshake: clear res_valid_o, grant_o and err_o. Set pointer = (g+1) mod NUM_REQ. Go to IDLE.
  - No new grant is issued in the same cycle. Re-arbitration costs one cycle in IDLE.
- Ownership: dropping req_i[g] during a job does not release ownership; the job runs to response. Requests raised by others during a job wait for IDLE.
- Fairness: with all requesters asserting continuously, the grant order is 0,1,...,NUM_REQ-1,0,...
- mac_terms_o stays constant from grant until return to IDLE.
- Timer width: clog2(TIMEOUT_CYCLES).

Decomposition:
- mac_pkg:
  - state enum sched_state_e {IDLE, STREAM, WAIT_BUSY, WAIT_IDLE, RESP}.
  - Default constants for DATA_WIDTH/ADDR_LINES.
  - Function onehot_to_idx.
- Sub-module rr_arbiter:
  - Parameter N. Inputs req vector and pointer; output one-hot grant.
  - Purely combinational rotate-priority-rotate. Stateless; the pointer lives in the scheduler.

Test Plan:
- Single job: req 0, terms=3, four samples 1,2,3,4 with last on 4. Expect:
  - grant_o=0001 one cycle after req.
  - Four mac_wr_en_o pulses, mac_last_o on the fourth, mac_terms_o=3 throughout.
  - After mac idle low→high, res_valid_o=0001 with result_o equal to the mac_result_i value at the rise.
- Contention: req_i=1111 continuous, one sample per job → grants in order 0001,0010,0100,1000,0001; each grant follows the prior response handshake by exactly one cycle (IDLE).
- Back-pressure: mac_full_i high for 5 cycles mid-stream with valid_i held → ready_o low, no mac_wr_en_o; the held sample is written exactly once when full drops.
- Timeout: TIMEOUT_CYCLES=16, mac_idle_i stuck high after last → RESP after 16 cycles in WAIT_BUSY, err_o=1, result_o=0; next job is granted normally.
- Response stall plus late request: res_ready_i low 10 cycles → res_valid_o and result_o stable. Requester 2 asserting req during RESP is granted only after the handshake.
- Async reset mid-STREAM: all outputs 0 immediately, state IDLE, pointer 0; a subsequent req_i=0100 gets grant_o=0100.
